// File: rtl/eth_tx_arb.sv
// rtl/eth_tx_arb.sv - round-robin GMII TX arbiter: preamble/SFD, payload forwarding, optional FCS, IFG
// Optional FCS append is enabled by defining ETH_TX_ARB_FCS_EN.
module eth_tx_arb #(
  parameter int N   = 2,
  parameter int IFG = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           tx_clk,
  output logic [7:0]     tx_dat,
  output logic           tx_en,
  output logic           tx_er,
  output logic [2:0]     grant,
  output logic           busy
);
  localparam int CW = $clog2(IFG + 8);

  // Each state decides what the output registers carry on the following cycle.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SFD  = 3'd2,
    DATA = 3'd3,
`ifdef ETH_TX_ARB_FCS_EN
    FCS  = 3'd4,
`endif
    GAP  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    grant_d;
  logic [7:0]    dat_d;
  logic          en_d, er_d, busy_d;
  logic [7:0]    valid8, last8;
  logic [3:0]    rr_idx;
  logic [2:0]    sel;
  logic          any_valid, cur_valid, cur_last;
  logic [7:0]    cur_data;
`ifdef ETH_TX_ARB_FCS_EN
  logic [31:0]   crc_q, crc_d, fcs;

  // Reflected CRC-32 (0xEDB88320 is 0x04C11DB7 bit-reversed), data LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction
`endif

  assign tx_clk    = clk;
  assign valid8    = 8'(req_valid);
  assign last8     = 8'(req_last);
  assign any_valid = |req_valid;
  assign cur_valid = valid8[grant];
  assign cur_last  = last8[grant];

  always_comb begin
    cur_data  = 8'h00;
    req_ready = '0;
    for (int k = 0; k < N; k++) begin
      if (grant == 3'(k)) cur_data = req_data[8*k +: 8];
      req_ready[k] = (state_q == DATA) && (grant == 3'(k));
    end
  end

  // Walk downwards so the source nearest ptr+1 is the last one written.
  always_comb begin
    sel    = '0;
    rr_idx = '0;
    for (int i = N; i >= 1; i--) begin
      rr_idx = {1'b0, ptr_q} + 4'(i);
      if (rr_idx >= 4'(N)) rr_idx = rr_idx - 4'(N);
      if (valid8[rr_idx[2:0]]) sel = rr_idx[2:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant;
    dat_d   = 8'h00;
    en_d    = 1'b0;
    er_d    = 1'b0;
    busy_d  = 1'b1;
`ifdef ETH_TX_ARB_FCS_EN
    crc_d   = crc_q;
    fcs     = ~crc_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = any_valid;
        if (any_valid) begin
          grant_d = sel;
          ptr_d   = sel;
          state_d = PRE;
          cnt_d   = '0;
          en_d    = 1'b1;
          dat_d   = 8'h55;
`ifdef ETH_TX_ARB_FCS_EN
          crc_d   = 32'hFFFFFFFF;
`endif
        end
      end
      PRE: begin
        en_d  = 1'b1;
        dat_d = 8'h55;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(5)) state_d = SFD;
      end
      SFD: begin
        en_d    = 1'b1;
        dat_d   = 8'hD5;
        state_d = DATA;
      end
      DATA: begin
        en_d = 1'b1;
        if (cur_valid) begin
          dat_d = cur_data;
`ifdef ETH_TX_ARB_FCS_EN
          crc_d = crc_step(crc_q, cur_data);
`endif
          if (cur_last) begin
            cnt_d = '0;
`ifdef ETH_TX_ARB_FCS_EN
            state_d = FCS;
`else
            state_d = GAP;
`endif
          end
        end else begin
          er_d = 1'b1;
        end
      end
`ifdef ETH_TX_ARB_FCS_EN
      FCS: begin
        en_d  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        case (cnt_q[1:0])
          2'd0:    dat_d = fcs[7:0];
          2'd1:    dat_d = fcs[15:8];
          2'd2:    dat_d = fcs[23:16];
          default: dat_d = fcs[31:24];
        endcase
        if (cnt_q == CW'(3)) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
`endif
      GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(IFG - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 3'(N - 1);
      grant   <= '0;
      tx_dat  <= 8'h00;
      tx_en   <= 1'b0;
      tx_er   <= 1'b0;
      busy    <= 1'b0;
`ifdef ETH_TX_ARB_FCS_EN
      crc_q   <= 32'hFFFFFFFF;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant   <= grant_d;
      tx_dat  <= dat_d;
      tx_en   <= en_d;
      tx_er   <= er_d;
      busy    <= busy_d;
`ifdef ETH_TX_ARB_FCS_EN
      crc_q   <= crc_d;
`endif
    end
  end
endmodule

// File: tb/tb_eth_tx_arb.sv
// tb/tb_eth_tx_arb.sv - directed self-checking bench for eth_tx_arb
// Expectations follow ETH_TX_ARB_FCS_EN when it is defined for the whole compile.
module tb_eth_tx_arb;
  localparam int N   = 2;
  localparam int IFG = 12;
`ifdef ETH_TX_ARB_FCS_EN
  localparam int FCSL = 4;
`else
  localparam int FCSL = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_clk;
  logic [7:0]     tx_dat;
  logic           tx_en, tx_er;
  logic [2:0]     grant;
  logic           busy;

  eth_tx_arb #(.N(N), .IFG(IFG)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_clk(tx_clk), .tx_dat(tx_dat),
    .tx_en(tx_en), .tx_er(tx_er), .grant(grant), .busy(busy)
  );

  always #4 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Per-source byte queues {last, data}, plus optional stall before byte index stall_pos.
  logic [8:0] sq [N][$];
  int         sent [N];
  int         stall_pos [N];
  int         stall_rem [N];
  logic [7:0] l_dat [$];
  logic       l_en [$];
  logic       l_er [$];
  logic       l_busy [$];
  logic [2:0] l_grant [$];
  int         rdy_bad = 0;
  logic [N-1:0] acc = '0;

  initial begin
    for (int k = 0; k < N; k++) begin
      sent[k] = 0; stall_pos[k] = 0; stall_rem[k] = 0;
    end
    forever begin
      @(negedge clk);
      l_dat.push_back(tx_dat);
      l_en.push_back(tx_en);
      l_er.push_back(tx_er);
      l_busy.push_back(busy);
      l_grant.push_back(grant);
      for (int k = 0; k < N; k++) begin
        if (acc[k] && sq[k].size() > 0) begin
          void'(sq[k].pop_front());
          sent[k]++;
        end
        if (req_ready[k] && grant != 3'(k)) rdy_bad++;
        req_valid[k] = 1'b0;
        req_last[k] = 1'b0;
        req_data[8*k +: 8] = 8'h00;
        if (sq[k].size() > 0) begin
          if (stall_rem[k] > 0 && sent[k] == stall_pos[k]) begin
            stall_rem[k]--;
          end else begin
            req_valid[k] = 1'b1;
            req_data[8*k +: 8] = sq[k][0][7:0];
            req_last[k] = sq[k][0][8];
          end
        end
      end
      acc = req_valid & req_ready;
    end
  end

  function automatic logic [31:0] fcs_of(input logic [7:0] base, input int len);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      b = base + 8'(i);
      c = c ^ {24'h0, b};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_frame(input int k, input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) sq[k].push_back({i == len - 1, base + 8'(i)});
  endtask

  task automatic start_log();
    l_dat.delete(); l_en.delete(); l_er.delete(); l_busy.delete(); l_grant.delete();
    rdy_bad = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < N; k++) begin
      sq[k].delete(); sent[k] = 0; stall_rem[k] = 0; stall_pos[k] = 0;
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
  endtask

  int rs [$];
  int rl [$];

  task automatic scan_runs();
    rs.delete(); rl.delete();
    for (int i = 0; i < l_en.size(); i++) begin
      if (l_en[i]) begin
        if (i == 0 || !l_en[i-1]) begin
          rs.push_back(i);
          rl.push_back(0);
        end
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int f, input logic [7:0] base,
                             input int len, input logic [2:0] g);
    int s;
    logic [31:0] fc;
    if (f >= rs.size()) return;
    s = rs[f];
    fc = fcs_of(base, len);
    chk($sformatf("%s.len", tag), 32'(rl[f]), 32'(8 + len + FCSL));
    chk($sformatf("%s.grant", tag), 32'(l_grant[s]), 32'(g));
    for (int j = 0; j < 7; j++) chk($sformatf("%s.pre%0d", tag, j), 32'(l_dat[s+j]), 32'h55);
    chk($sformatf("%s.sfd", tag), 32'(l_dat[s+7]), 32'hD5);
    for (int j = 0; j < len; j++)
      chk($sformatf("%s.pay%0d", tag, j), 32'(l_dat[s+8+j]), 32'(base + 8'(j)));
    if (FCSL == 4) begin
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s.fcs%0d", tag, j), 32'(l_dat[s+8+len+j]), 32'(fc[8*j +: 8]));
    end
  endtask

  task automatic check_busy_tail(input string tag);
    int e;
    int hi;
    if (rs.size() == 0) return;
    e = rs[0] + rl[0];
    hi = 0;
    for (int j = 0; j < IFG; j++) if (l_en[e+j]) hi++;
    chk($sformatf("%s.gap_low", tag), 32'(hi), 32'd0);
    chk($sformatf("%s.busy_pre_fall", tag), 32'(l_busy[e+IFG-1]), 32'd1);
    chk($sformatf("%s.busy_fall", tag), 32'(l_busy[e+IFG]), 32'd0);
  endtask

  int found;
  logic [31:0] crc_word;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.tx_en", 32'(tx_en), 32'd0);
    chk("rst.tx_dat", 32'(tx_dat), 32'd0);
    chk("rst.tx_er", 32'(tx_er), 32'd0);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.grant", 32'(grant), 32'd0);

    // "123456789" from source 0
    do_reset();
    start_log();
    push_frame(0, 8'h31, 9);
    repeat (50) @(posedge clk);
    scan_runs();
    chk("t1.frames", 32'(rs.size()), 32'd1);
    chk("t1.idle_first", 32'(l_en[0]), 32'd0);
    chk("t1.latency", 32'(rs.size() > 0 ? rs[0] : -1), 32'd1);
    chk("t1.busy_rise", 32'(l_busy[1]), 32'd1);
    check_frame("t1", 0, 8'h31, 9, 3'd0);
    if (FCSL == 4 && rs.size() > 0) begin
      crc_word = {l_dat[rs[0]+20], l_dat[rs[0]+19], l_dat[rs[0]+18], l_dat[rs[0]+17]};
      chk("t1.check_value", crc_word, 32'hCBF43926);
    end
    check_busy_tail("t1");

    // Both sources continuously valid, two 4-byte frames each
    do_reset();
    start_log();
    push_frame(0, 8'hA0, 4); push_frame(0, 8'hA8, 4);
    push_frame(1, 8'hB0, 4); push_frame(1, 8'hB8, 4);
    repeat (140) @(posedge clk);
    scan_runs();
    chk("t2.frames", 32'(rs.size()), 32'd4);
    check_frame("t2.f0", 0, 8'hA0, 4, 3'd0);
    check_frame("t2.f1", 1, 8'hB0, 4, 3'd1);
    check_frame("t2.f2", 2, 8'hA8, 4, 3'd0);
    check_frame("t2.f3", 3, 8'hB8, 4, 3'd1);
    for (int f = 0; f + 1 < rs.size(); f++)
      chk($sformatf("t2.gap%0d", f), 32'(rs[f+1] - (rs[f] + rl[f])), 32'(IFG));
    chk("t2.ready_leak", 32'(rdy_bad), 32'd0);

    // Underrun: source 0 withholds byte 3 for two cycles
    do_reset();
    start_log();
    stall_pos[0] = 3; stall_rem[0] = 2;
    push_frame(0, 8'h10, 6);
    repeat (50) @(posedge clk);
    scan_runs();
    chk("t3.frames", 32'(rs.size()), 32'd1);
    if (rs.size() > 0) begin
      logic [7:0] ed [8];
      logic       ee [8];
      ed = '{8'h10, 8'h11, 8'h12, 8'h00, 8'h00, 8'h13, 8'h14, 8'h15};
      ee = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      chk("t3.len", 32'(rl[0]), 32'(8 + 6 + 2 + FCSL));
      chk("t3.sfd", 32'(l_dat[rs[0]+7]), 32'hD5);
      for (int j = 0; j < 8; j++) begin
        chk($sformatf("t3.dat%0d", j), 32'(l_dat[rs[0]+8+j]), 32'(ed[j]));
        chk($sformatf("t3.er%0d", j), 32'(l_er[rs[0]+8+j]), 32'(ee[j]));
      end
      if (FCSL == 4) begin
        crc_word = fcs_of(8'h10, 6);
        for (int j = 0; j < 4; j++)
          chk($sformatf("t3.fcs%0d", j), 32'(l_dat[rs[0]+16+j]), 32'(crc_word[8*j +: 8]));
      end
    end

    // 1-byte frame
    do_reset();
    start_log();
    push_frame(0, 8'hAB, 1);
    repeat (40) @(posedge clk);
    scan_runs();
    chk("t4.frames", 32'(rs.size()), 32'd1);
    check_frame("t4", 0, 8'hAB, 1, 3'd0);
    check_busy_tail("t4");

    // Reset during payload byte 3, then both sources request together
    do_reset();
    start_log();
    push_frame(0, 8'h40, 8);
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(posedge clk);
      #1;
      if (tx_en && tx_dat == 8'h42) found = 1;
    end
    chk("t5.reached_byte3", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5.async_en", 32'(tx_en), 32'd0);
    chk("t5.async_ready", 32'(req_ready), 32'd0);
    chk("t5.async_busy", 32'(busy), 32'd0);
    do_reset();
    start_log();
    push_frame(0, 8'h50, 3);
    push_frame(1, 8'h58, 3);
    repeat (30) @(posedge clk);
    scan_runs();
    chk("t5.frame_seen", 32'(rs.size() > 0), 32'd1);
    chk("t5.latency", 32'(rs.size() > 0 ? rs[0] : -1), 32'd1);
    check_frame("t5", 0, 8'h50, 3, 3'd0);

    // 5-byte frame, exact tx_en length
    do_reset();
    start_log();
    push_frame(0, 8'h60, 5);
    repeat (40) @(posedge clk);
    scan_runs();
    chk("t6.frames", 32'(rs.size()), 32'd1);
    check_frame("t6", 0, 8'h60, 5, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
